// File: rtl/dm_byte_store_unit_pkg.sv
// Shared encodings for the M-stage data memory: store/load type codes,
// byte-lane enable patterns and the default array depth.
package dm_byte_store_unit_pkg;

  localparam int DM_DEPTH_LOG2 = 12;

  localparam logic [1:0] ST_NONE = 2'b00;
  localparam logic [1:0] ST_W    = 2'b01;
  localparam logic [1:0] ST_H    = 2'b10;
  localparam logic [1:0] ST_B    = 2'b11;

  localparam logic [2:0] LD_NONE = 3'b000;
  localparam logic [2:0] LD_W    = 3'b001;
  localparam logic [2:0] LD_H    = 3'b010;
  localparam logic [2:0] LD_HU   = 3'b011;
  localparam logic [2:0] LD_B    = 3'b100;
  localparam logic [2:0] LD_BU   = 3'b101;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_HLO  = 4'b0011;
  localparam logic [3:0] BE_HHI  = 4'b1100;
  localparam logic [3:0] BE_B0   = 4'b0001;

  // 110/111 are unused encodings and behave like "no load".
  function automatic logic ld_is_legal(input logic [2:0] t);
    return (t >= LD_W) && (t <= LD_BU);
  endfunction

endpackage

// File: rtl/dm_byte_store_unit_load_extend.sv
// Selects the half/byte addressed by lane out of a 32-bit word and
// sign- or zero-extends it according to the load type.
module dm_load_extend
  import dm_byte_store_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  load_type,
  output logic [31:0] result
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  // Lane select followed by extension; unknown types yield zero.
  always_comb begin
    half_sel = lane[1] ? word[31:16] : word[15:0];
    byte_sel = word[7:0];
    case (lane)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    result = '0;
    case (load_type)
      LD_W:  result = word;
      LD_H:  result = {{16{half_sel[15]}}, half_sel};
      LD_HU: result = {16'h0000, half_sel};
      LD_B:  result = {{24{byte_sel[7]}}, byte_sel};
      LD_BU: result = {24'h000000, byte_sel};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/dm_byte_store_unit.sv
// M-stage data memory: byte-lane stores, aligned extended loads, and the
// M->W registers for load data and address-error flags.
module dm_byte_store_unit
  import dm_byte_store_unit_pkg::*;
#(
  parameter int          DEPTH_LOG2 = DM_DEPTH_LOG2,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        M_valid,
  input  logic [1:0]  M_store_type,
  input  logic [2:0]  M_load_type,
  input  logic [31:0] M_addr,
  input  logic [31:0] M_wdata,
  output logic [3:0]  M_byte_en,
  output logic [31:0] W_rdata,
  output logic        W_adel,
  output logic        W_ades
);

  localparam int          DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [32:0] BYTE_SPAN = 33'd4 << DEPTH_LOG2;

  // Array is not reset; it only starts out zeroed.
  logic [31:0] mem [DEPTH] = '{default: '0};

  logic [31:0]           off;
  logic                  in_range;
  logic [DEPTH_LOG2-1:0] widx;
  logic [1:0]            lane;

  logic        st_active, st_misal, st_fault;
  logic        ld_active, ld_misal, ld_fault;
  logic [3:0]  byte_en;
  logic [31:0] wr_data;
  logic [31:0] rd_word;
  logic [31:0] ld_ext;

  logic [31:0] w_rdata_d, w_rdata_q;
  logic        w_adel_d,  w_adel_q;
  logic        w_ades_d,  w_ades_q;

  // Address decode: the base is removed with 32-bit wrap and anything past
  // the array faults instead of aliasing.
  always_comb begin
    off      = M_addr - BASE_ADDR;
    in_range = {1'b0, off} < BYTE_SPAN;
    widx     = off[DEPTH_LOG2+1:2];
    lane     = off[1:0];
  end

  // Store legality, lane enables and replicated write data. Reset masks the
  // enables so a store caught by reset never reaches the array.
  always_comb begin
    st_active = M_valid && (M_store_type != ST_NONE);
    st_misal  = 1'b0;
    byte_en   = BE_NONE;
    wr_data   = M_wdata;
    case (M_store_type)
      ST_W: begin
        st_misal = (lane != 2'b00);
        byte_en  = BE_WORD;
        wr_data  = M_wdata;
      end
      ST_H: begin
        st_misal = lane[0];
        byte_en  = lane[1] ? BE_HHI : BE_HLO;
        wr_data  = {M_wdata[15:0], M_wdata[15:0]};
      end
      ST_B: begin
        st_misal = 1'b0;
        byte_en  = BE_B0 << lane;
        wr_data  = {4{M_wdata[7:0]}};
      end
      default: begin
        st_misal = 1'b0;
        byte_en  = BE_NONE;
        wr_data  = M_wdata;
      end
    endcase
    st_fault = st_active && (st_misal || !in_range);
    if (!st_active || st_fault || reset) byte_en = BE_NONE;
  end

  assign M_byte_en = byte_en;

  // Per-lane array write; untouched lanes keep their contents.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (byte_en[b]) mem[widx][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

  assign rd_word = mem[widx];

  dm_load_extend u_ext (
    .word      (rd_word),
    .lane      (lane),
    .load_type (M_load_type),
    .result    (ld_ext)
  );

  // Load legality and next W-stage values. A store type wins over any load
  // type, so a mixed decode produces neither data nor a load fault.
  always_comb begin
    ld_active = M_valid && (M_store_type == ST_NONE) && ld_is_legal(M_load_type);
    case (M_load_type)
      LD_W:        ld_misal = (lane != 2'b00);
      LD_H, LD_HU: ld_misal = lane[0];
      default:     ld_misal = 1'b0;
    endcase
    ld_fault  = ld_active && (ld_misal || !in_range);
    w_adel_d  = ld_fault;
    w_ades_d  = st_fault;
    w_rdata_d = (ld_active && !ld_fault) ? ld_ext : 32'h0;
  end

  // W-stage registers, cleared immediately by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_rdata_q <= '0;
      w_adel_q  <= 1'b0;
      w_ades_q  <= 1'b0;
    end else begin
      w_rdata_q <= w_rdata_d;
      w_adel_q  <= w_adel_d;
      w_ades_q  <= w_ades_d;
    end
  end

  assign W_rdata = w_rdata_q;
  assign W_adel  = w_adel_q;
  assign W_ades  = w_ades_q;

endmodule

// File: tb/tb_dm_byte_store_unit.sv
// Directed vector table for dm_byte_store_unit plus a hand-written reset
// sequence.
module tb_dm_byte_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        M_valid;
  logic [1:0]  M_store_type;
  logic [2:0]  M_load_type;
  logic [31:0] M_addr;
  logic [31:0] M_wdata;
  logic [3:0]  M_byte_en;
  logic [31:0] W_rdata;
  logic        W_adel;
  logic        W_ades;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dm_byte_store_unit dut (
    .clk          (clk),
    .reset        (reset),
    .M_valid      (M_valid),
    .M_store_type (M_store_type),
    .M_load_type  (M_load_type),
    .M_addr       (M_addr),
    .M_wdata      (M_wdata),
    .M_byte_en    (M_byte_en),
    .W_rdata      (W_rdata),
    .W_adel       (W_adel),
    .W_ades       (W_ades)
  );

  typedef struct {
    logic        v;
    logic [1:0]  st;
    logic [2:0]  ld;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rd;
    logic        adel;
    logic        ades;
  } vec_t;

  localparam int NV = 23;
  vec_t tbl [NV];

  function automatic vec_t mk(logic v, logic [1:0] st, logic [2:0] ld,
                              logic [31:0] addr, logic [31:0] wdata,
                              logic [3:0] be, logic [31:0] rd,
                              logic adel, logic ades);
    vec_t r;
    r.v = v; r.st = st; r.ld = ld; r.addr = addr; r.wdata = wdata;
    r.be = be; r.rd = rd; r.adel = adel; r.ades = ades;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] st, input logic [2:0] ld,
                       input logic [31:0] addr, input logic [31:0] wdata);
    M_valid = v; M_store_type = st; M_load_type = ld; M_addr = addr; M_wdata = wdata;
  endtask

  initial begin
    //                v     st     ld      addr          wdata         be       rd            adel  ades
    tbl[0]  = mk(1'b1, 2'b01, 3'b000, 32'h0000_0010, 32'h1234_5678, 4'b1111, 32'h0,        1'b0, 1'b0); // sw
    tbl[1]  = mk(1'b1, 2'b00, 3'b001, 32'h0000_0010, 32'h0,         4'b0000, 32'h1234_5678, 1'b0, 1'b0); // lw
    tbl[2]  = mk(1'b1, 2'b11, 3'b000, 32'h0000_0013, 32'h0000_00AB, 4'b1000, 32'h0,        1'b0, 1'b0); // sb
    tbl[3]  = mk(1'b1, 2'b00, 3'b001, 32'h0000_0010, 32'h0,         4'b0000, 32'hAB34_5678, 1'b0, 1'b0);
    tbl[4]  = mk(1'b1, 2'b10, 3'b000, 32'h0000_0012, 32'h0000_8001, 4'b1100, 32'h0,        1'b0, 1'b0); // sh
    tbl[5]  = mk(1'b1, 2'b00, 3'b010, 32'h0000_0012, 32'h0,         4'b0000, 32'hFFFF_8001, 1'b0, 1'b0); // lh
    tbl[6]  = mk(1'b1, 2'b00, 3'b011, 32'h0000_0012, 32'h0,         4'b0000, 32'h0000_8001, 1'b0, 1'b0); // lhu
    tbl[7]  = mk(1'b1, 2'b00, 3'b100, 32'h0000_0013, 32'h0,         4'b0000, 32'hFFFF_FF80, 1'b0, 1'b0); // lb
    tbl[8]  = mk(1'b1, 2'b00, 3'b101, 32'h0000_0012, 32'h0,         4'b0000, 32'h0000_0001, 1'b0, 1'b0); // lbu
    tbl[9]  = mk(1'b1, 2'b01, 3'b000, 32'h0000_0011, 32'hFFFF_FFFF, 4'b0000, 32'h0,        1'b0, 1'b1); // sw misaligned
    tbl[10] = mk(1'b1, 2'b00, 3'b001, 32'h0000_0010, 32'h0,         4'b0000, 32'h8001_5678, 1'b0, 1'b0);
    tbl[11] = mk(1'b1, 2'b00, 3'b010, 32'h0000_0003, 32'h0,         4'b0000, 32'h0,        1'b1, 1'b0); // lh misaligned
    tbl[12] = mk(1'b1, 2'b00, 3'b001, 32'h0000_4000, 32'h0,         4'b0000, 32'h0,        1'b1, 1'b0); // out of range
    tbl[13] = mk(1'b0, 2'b01, 3'b000, 32'h0000_0010, 32'hFFFF_FFFF, 4'b0000, 32'h0,        1'b0, 1'b0); // bubble
    tbl[14] = mk(1'b1, 2'b00, 3'b001, 32'h0000_0010, 32'h0,         4'b0000, 32'h8001_5678, 1'b0, 1'b0);
    tbl[15] = mk(1'b1, 2'b01, 3'b001, 32'h0000_0014, 32'h55AA_55AA, 4'b1111, 32'h0,        1'b0, 1'b0); // st+ld
    tbl[16] = mk(1'b1, 2'b00, 3'b001, 32'h0000_0014, 32'h0,         4'b0000, 32'h55AA_55AA, 1'b0, 1'b0);
    tbl[17] = mk(1'b1, 2'b11, 3'b000, 32'h0000_4001, 32'h0000_0011, 4'b0000, 32'h0,        1'b0, 1'b1); // sb out of range
    tbl[18] = mk(1'b1, 2'b00, 3'b011, 32'h0000_0010, 32'h0,         4'b0000, 32'h0000_5678, 1'b0, 1'b0);
    tbl[19] = mk(1'b1, 2'b00, 3'b100, 32'h0000_0010, 32'h0,         4'b0000, 32'h0000_0078, 1'b0, 1'b0);
    tbl[20] = mk(1'b1, 2'b00, 3'b110, 32'h0000_0010, 32'h0,         4'b0000, 32'h0,        1'b0, 1'b0); // reserved ld
    tbl[21] = mk(1'b1, 2'b10, 3'b000, 32'h0000_0011, 32'h0000_FFFF, 4'b0000, 32'h0,        1'b0, 1'b1); // sh misaligned
    tbl[22] = mk(1'b1, 2'b00, 3'b101, 32'h0000_0013, 32'h0,         4'b0000, 32'h0000_0080, 1'b0, 1'b0);

    reset = 1'b1;
    drive(1'b0, 2'b00, 3'b000, 32'h0, 32'h0);
    #12;
    chk("reset_rdata", W_rdata, 32'h0);
    chk("reset_adel", {31'h0, W_adel}, 32'h0);
    chk("reset_ades", {31'h0, W_ades}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Inputs change 1 time unit after a rising edge; enables are sampled
    // mid-cycle and W outputs just after the following edge.
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].v, tbl[i].st, tbl[i].ld, tbl[i].addr, tbl[i].wdata);
      #2;
      chk($sformatf("v%0d_byte_en", i), {28'h0, M_byte_en}, {28'h0, tbl[i].be});
      @(posedge clk); #1;
      chk($sformatf("v%0d_rdata", i), W_rdata, tbl[i].rd);
      chk($sformatf("v%0d_adel", i), {31'h0, W_adel}, {31'h0, tbl[i].adel});
      chk($sformatf("v%0d_ades", i), {31'h0, W_ades}, {31'h0, tbl[i].ades});
    end

    // Reset arriving while a store sits in M: W clears at once and the
    // store never lands.
    drive(1'b1, 2'b00, 3'b001, 32'h0000_0010, 32'h0);
    @(posedge clk); #1;
    chk("pre_reset_rdata", W_rdata, 32'h8001_5678);
    drive(1'b1, 2'b00, 3'b010, 32'h0000_0003, 32'h0);
    @(posedge clk); #1;
    chk("pre_reset_adel", {31'h0, W_adel}, 32'h1);
    drive(1'b1, 2'b01, 3'b000, 32'h0000_0020, 32'hDEAD_BEEF);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_adel", {31'h0, W_adel}, 32'h0);
    chk("async_reset_be", {28'h0, M_byte_en}, 32'h0);
    @(posedge clk); #1;
    chk("reset_hold_rdata", W_rdata, 32'h0);
    chk("reset_hold_ades", {31'h0, W_ades}, 32'h0);
    reset = 1'b0;
    drive(1'b1, 2'b00, 3'b001, 32'h0000_0020, 32'h0);
    @(posedge clk); #1;
    chk("post_reset_lw20", W_rdata, 32'h0000_0000);
    chk("post_reset_adel", {31'h0, W_adel}, 32'h0);

    // Back-to-back store then load of the same word.
    drive(1'b1, 2'b11, 3'b000, 32'h0000_0021, 32'h0000_00C3);
    @(posedge clk); #1;
    drive(1'b1, 2'b00, 3'b001, 32'h0000_0020, 32'h0);
    @(posedge clk); #1;
    chk("st_ld_fwd", W_rdata, 32'h0000_C300);

    drive(1'b0, 2'b00, 3'b000, 32'h0, 32'h0);
    @(posedge clk); #1;
    chk("idle_rdata", W_rdata, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
